// File: rtl/mem_access_unit_if.sv
// mem_access_unit_if: EX->MEM op request plus single-port data-RAM bundle.
interface mem_access_unit_if #(parameter int RAM_AW = 8);
  logic              valid_in;
  logic              flush;
  logic              L_type;
  logic              S_type;
  logic [2:0]        funct3;
  logic [31:0]       addr;
  logic [31:0]       store_data;
  logic              data_RAM_R_en;
  logic              data_RAM_W_en;
  logic [RAM_AW-1:0] ram_addr;
  logic [31:0]       ram_wdata;
  logic [31:0]       ram_rdata;
  logic [31:0]       load_data;
  logic              mem_fault;
  logic              pipe_ready_go;
  modport master (
    output valid_in, flush, L_type, S_type, funct3, addr, store_data, ram_rdata,
    input  data_RAM_R_en, data_RAM_W_en, ram_addr, ram_wdata, load_data, mem_fault, pipe_ready_go
  );
  modport slave (
    input  valid_in, flush, L_type, S_type, funct3, addr, store_data, ram_rdata,
    output data_RAM_R_en, data_RAM_W_en, ram_addr, ram_wdata, load_data, mem_fault, pipe_ready_go
  );
endinterface

// File: rtl/mem_access_unit.sv
// mem_access_unit: MEM stage with sub-word loads and read-modify-write sub-word stores.
module mem_access_unit #(
  parameter int RAM_AW  = 8,
  parameter int RAM_LAT = 1
) (
  input logic          clk,
  input logic          rst,
  mem_access_unit_if.slave bus
);
  localparam int CW = $clog2(RAM_LAT + 1);
  typedef enum logic [1:0] {IDLE, RD_WAIT, WRITE, DONE} state_t;
  state_t state, state_n;
  logic [CW-1:0] cnt, cnt_n;
  logic [31:0] load_q, load_n, merge_q, merge_n;
  logic op, legal, misalign, fault, last;
  logic [4:0] sh;
  logic [31:0] mask, lane, ext, merged;
  logic unused;
  assign unused   = &{1'b0, bus.addr[31:RAM_AW+2]};
  assign op       = bus.valid_in & (bus.L_type | bus.S_type);
  assign legal    = bus.L_type ? (bus.funct3 inside {3'd0, 3'd1, 3'd2, 3'd4, 3'd5})
                               : (bus.funct3 inside {3'd0, 3'd1, 3'd2});
  assign misalign = (bus.funct3[1:0] == 2'b01 & bus.addr[0]) | (bus.funct3[1:0] == 2'b10 & |bus.addr[1:0]);
  assign fault    = ~legal | misalign;
  assign last     = cnt == CW'(RAM_LAT);
  assign sh       = {bus.addr[1:0], 3'b000};
  assign mask     = bus.funct3[1:0] == 2'b00 ? 32'h0000_00ff :
                    bus.funct3[1:0] == 2'b01 ? 32'h0000_ffff : 32'hffff_ffff;
  assign lane     = (bus.ram_rdata >> sh) & mask;
  assign ext      = (bus.funct3[2] | bus.funct3[1]) ? lane :
                    bus.funct3[0] ? {{16{lane[15]}}, lane[15:0]} : {{24{lane[7]}}, lane[7:0]};
  // only the addressed lane changes; the rest of the word comes from the RAM read
  assign merged   = (merge_q & ~(mask << sh)) | ((bus.store_data & mask) << sh);
  assign bus.ram_addr  = bus.addr[RAM_AW+1:2];
  assign bus.load_data = load_q;
  always_comb begin
    state_n = state;
    cnt_n   = cnt;
    load_n  = load_q;
    merge_n = merge_q;
    bus.data_RAM_R_en = 1'b0;
    bus.data_RAM_W_en = 1'b0;
    bus.ram_wdata     = '0;
    bus.mem_fault     = 1'b0;
    bus.pipe_ready_go = 1'b0;
    if (rst) begin
      state_n = IDLE;
    end else if (bus.flush) begin
      state_n = IDLE;
      cnt_n   = '0;
    end else begin
      case (state)
        IDLE: begin
          if (!op) begin
            bus.pipe_ready_go = 1'b1;
          end else if (fault) begin
            bus.pipe_ready_go = 1'b1;
            bus.mem_fault     = 1'b1;
          end else if (!bus.L_type && bus.funct3[1:0] == 2'b10) begin
            bus.data_RAM_W_en = 1'b1;
            bus.ram_wdata     = bus.store_data;
            bus.pipe_ready_go = 1'b1;
          end else begin
            bus.data_RAM_R_en = 1'b1;
            state_n = RD_WAIT;
            cnt_n   = CW'(1);
          end
        end
        RD_WAIT: begin
          if (!last) begin
            cnt_n = cnt + 1'b1;
          end else begin
            cnt_n   = '0;
            state_n = bus.L_type ? DONE : WRITE;
            load_n  = bus.L_type ? ext : load_q;
            merge_n = bus.L_type ? merge_q : bus.ram_rdata;
          end
        end
        WRITE: begin
          bus.data_RAM_W_en = 1'b1;
          bus.ram_wdata     = merged;
          bus.pipe_ready_go = 1'b1;
          state_n = IDLE;
        end
        default: begin
          bus.pipe_ready_go = 1'b1;
          state_n = IDLE;
        end
      endcase
    end
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      state   <= IDLE;
      cnt     <= '0;
      load_q  <= '0;
      merge_q <= '0;
    end else begin
      state   <= state_n;
      cnt     <= cnt_n;
      load_q  <= load_n;
      merge_q <= merge_n;
    end
  end
endmodule

// File: tb/tb_mem_access_unit.sv
// tb_mem_access_unit: directed plus random ops against a behavioural memory/extension model.
module tb_mem_access_unit;
  localparam int AW  = 8;
  localparam int LAT = 3;
  localparam logic [31:0] POISON = 32'hDEAD_BEEF;
  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;
  mem_access_unit_if #(.RAM_AW(AW)) bus ();
  mem_access_unit #(.RAM_AW(AW), .RAM_LAT(LAT)) dut (.clk(clk), .rst(rst), .bus(bus));
  logic [31:0] ram [256];
  logic [31:0] ref_mem [256];
  logic [31:0] rd_pipe [LAT];
  logic        poke = 1'b0;
  logic [7:0]  poke_idx = '0;
  logic [31:0] poke_val = '0;
  always @(posedge clk) begin
    if (poke) ram[poke_idx] <= poke_val;
    else if (bus.data_RAM_W_en) ram[bus.ram_addr] <= bus.ram_wdata;
    rd_pipe[0] <= bus.data_RAM_R_en ? ram[bus.ram_addr] : POISON;
    for (int i = 1; i < LAT; i++) rd_pipe[i] <= rd_pipe[i-1];
  end
  assign bus.ram_rdata = rd_pipe[LAT-1];
  int checks = 0;
  int failures = 0;
  logic [31:0] last_ld, last_wd;
  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask
  task automatic do_poke(input int idx, input logic [31:0] val);
    poke = 1'b1; poke_idx = 8'(idx); poke_val = val; ref_mem[idx] = val;
    @(posedge clk); #1;
    poke = 1'b0;
  endtask
  task automatic set_op(input logic v, l, s, input logic [2:0] f3, input logic [31:0] a, sd);
    bus.valid_in = v; bus.L_type = l; bus.S_type = s;
    bus.funct3 = f3; bus.addr = a; bus.store_data = sd;
  endtask
  // Called just after a rising edge; returns just after the edge that ends the completion cycle.
  task automatic run(input logic v, l, s, input logic [2:0] f3, input logic [31:0] a, sd);
    logic op, flt, legal;
    int nb, sh, idx, lat, n, rcnt, wcnt, exp_r, exp_w;
    logic [31:0] w, m, exp_ld, exp_wd, got_wd, got_ld, got_ra;
    logic got_flt;
    op    = v && (l || s);
    legal = l ? (f3 == 0 || f3 == 1 || f3 == 2 || f3 == 4 || f3 == 5) : (f3 <= 2);
    nb    = 1 << f3[1:0];
    flt   = op && (!legal || (a % nb) != 0);
    idx   = int'(a / 4) % 256;
    sh    = int'(a % 4) * 8;
    exp_ld = '0; exp_wd = '0;
    if (op && !flt) begin
      w = ref_mem[idx];
      m = (nb == 4) ? 32'hFFFF_FFFF : (32'd1 << (8 * nb)) - 1;
      if (l) begin
        exp_ld = (w >> sh) & m;
        if (!f3[2] && nb < 4 && exp_ld[8*nb-1]) exp_ld = exp_ld | ~m;
      end else begin
        exp_wd = (nb == 4) ? sd : ((w & ~(m << sh)) | ((sd & m) << sh));
        ref_mem[idx] = exp_wd;
      end
    end
    lat   = (!op || flt || (s && !l && nb == 4)) ? 0 : LAT + 1;
    exp_r = lat > 0 ? 1 : 0;
    exp_w = (op && !flt && s && !l) ? 1 : 0;
    set_op(v, l, s, f3, a, sd);
    n = 0; rcnt = 0; wcnt = 0; got_wd = '0;
    forever begin
      @(negedge clk);
      if (bus.data_RAM_R_en) rcnt++;
      if (bus.data_RAM_W_en) begin wcnt++; got_wd = bus.ram_wdata; end
      if (bus.pipe_ready_go || n > LAT + 5) break;
      @(posedge clk); #1;
      n++;
    end
    got_flt = bus.mem_fault; got_ld = bus.load_data; got_ra = 32'(bus.ram_addr);
    last_ld = got_ld; last_wd = got_wd;
    chk("latency", n, lat);
    chk("mem_fault", 32'(got_flt), 32'(flt));
    chk("read_count", rcnt, exp_r);
    chk("write_count", wcnt, exp_w);
    chk("ram_addr", got_ra, idx);
    if (exp_w == 1) chk("ram_wdata", got_wd, exp_wd);
    if (op && !flt && l) chk("load_data", got_ld, exp_ld);
    @(posedge clk); #1;
    bus.valid_in = 1'b0;
  endtask
  initial begin
    int lf[5];
    int sel, wc, bad;
    logic v, l, s;
    logic [2:0] f3;
    logic [31:0] a;
    lf = '{0, 1, 2, 4, 5};
    bus.flush = 1'b0;
    set_op(1'b1, 1'b0, 1'b1, 3'b010, 32'h30, 32'h1234_5678);
    @(negedge clk);
    chk("rst_r_en", 32'(bus.data_RAM_R_en), 0);
    chk("rst_w_en", 32'(bus.data_RAM_W_en), 0);
    chk("rst_go", 32'(bus.pipe_ready_go), 0);
    chk("rst_fault", 32'(bus.mem_fault), 0);
    chk("rst_wdata", bus.ram_wdata, 0);
    @(posedge clk); #1;
    for (int i = 0; i < 64; i++) do_poke(i, $urandom);
    chk("rst_load_data", bus.load_data, 0);
    rst = 1'b0; bus.valid_in = 1'b0;
    @(negedge clk);
    chk("post_rst_go", 32'(bus.pipe_ready_go), 1);
    chk("post_rst_en", 32'({bus.data_RAM_R_en, bus.data_RAM_W_en, bus.mem_fault}), 0);
    @(posedge clk); #1;
    do_poke(4, 32'h8765_4321);
    run(1, 1, 0, 3'b010, 32'h10, 0);
    chk("lw_const", last_ld, 32'h8765_4321);
    do_poke(4, 32'h80FF_0000);
    run(1, 1, 0, 3'b000, 32'h13, 0);
    chk("lb_const", last_ld, 32'hFFFF_FF80);
    run(1, 1, 0, 3'b100, 32'h13, 0);
    chk("lbu_const", last_ld, 32'h0000_0080);
    run(1, 1, 0, 3'b001, 32'h12, 0);
    chk("lh_const", last_ld, 32'hFFFF_80FF);
    do_poke(8, 32'h1122_3344);
    run(1, 0, 1, 3'b000, 32'h21, 32'h0000_00AB);
    chk("sb_const", last_wd, 32'h1122_AB44);
    do_poke(8, 32'h1122_3344);
    run(1, 0, 1, 3'b001, 32'h22, 32'h0000_BEEF);
    chk("sh_const", last_wd, 32'hBEEF_3344);
    run(1, 1, 0, 3'b010, 32'h20, 0);
    chk("ld_after_sh", last_ld, 32'hBEEF_3344);
    run(1, 0, 1, 3'b010, 32'h30, 32'hCAFE_F00D);
    run(1, 1, 0, 3'b010, 32'h31, 0);
    run(1, 1, 0, 3'b011, 32'h30, 0);
    run(1, 0, 1, 3'b100, 32'h30, 0);
    run(0, 1, 0, 3'b010, 32'h30, 0);
    set_op(1, 0, 1, 3'b000, 32'h24, 32'h5A);
    @(negedge clk);
    chk("flush_r_en", 32'(bus.data_RAM_R_en), 1);
    @(posedge clk); #1;
    bus.flush = 1'b1;
    @(negedge clk);
    chk("flush_en", 32'({bus.data_RAM_R_en, bus.data_RAM_W_en, bus.pipe_ready_go}), 0);
    @(posedge clk); #1;
    bus.flush = 1'b0; bus.valid_in = 1'b0;
    wc = 0;
    repeat (LAT + 3) begin
      @(negedge clk);
      if (bus.data_RAM_W_en) wc++;
    end
    chk("flush_no_write", wc, 0);
    @(posedge clk); #1;
    run(1, 0, 1, 3'b010, 32'h28, 32'h0BAD_F00D);
    for (int k = 0; k < 80; k++) begin
      sel = $urandom_range(0, 9);
      v = $urandom_range(0, 9) != 0;
      l = sel < 5;
      s = sel >= 5 && sel < 9;
      f3 = ($urandom_range(0, 4) == 0) ? 3'($urandom) : (l ? 3'(lf[$urandom_range(0, 4)]) : 3'($urandom_range(0, 2)));
      a = 32'($urandom_range(0, 255));
      if ($urandom_range(0, 3) != 0) a = a & ~((32'd1 << f3[1:0]) - 1);
      run(v, l, s, f3, a, $urandom);
    end
    set_op(1, 0, 1, 3'b000, 32'h40, 32'h77);
    for (int n = 0; n < LAT + 6; n++) begin
      @(negedge clk);
      if (bus.data_RAM_W_en) break;
      @(posedge clk); #1;
    end
    chk("write_reached", 32'(bus.data_RAM_W_en), 1);
    rst = 1'b1;
    #1;
    chk("rst_in_write_w_en", 32'(bus.data_RAM_W_en), 0);
    chk("rst_in_write_go", 32'(bus.pipe_ready_go), 0);
    @(posedge clk); #1;
    rst = 1'b0; bus.valid_in = 1'b0;
    chk("rst2_load_data", bus.load_data, 0);
    @(negedge clk);
    chk("rst2_en", 32'({bus.data_RAM_R_en, bus.data_RAM_W_en, bus.mem_fault}), 0);
    chk("rst2_go", 32'(bus.pipe_ready_go), 1);
    chk("rst2_word", ram[16], ref_mem[16]);
    @(posedge clk); #1;
    bad = 0;
    for (int i = 0; i < 64; i++) if (ram[i] !== ref_mem[i]) bad++;
    chk("ram_contents", bad, 0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
